// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the encrypt datapath stages.
//   - AES_NR, AES_RCON_INIT : round count and first round-constant
//   - aes_state_t / aes_word_t / aes_byte_t : datapath widths
//   - xtime() : GF(2^8) multiply-by-2 (poly 0x11b); also used by MixColumns
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_NR        = 10;
    localparam logic [7:0]  AES_RCON_INIT = 8'h01;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_WORD_W  = 32;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;
    typedef logic [7:0]             aes_byte_t;

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box (one byte). Used 4x for SubWord in the key
// schedule and 16x for SubBytes.
// Ports:
//   i_byte  in  8   input byte
//   o_byte  out 8   S-box substitution of i_byte
// -----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0x00 occupies the most significant byte of the table.
    localparam logic [2047:0] LP_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n sits at bit offset 8*(255-n); 255-n is simply ~n for a byte.
    assign o_byte = LP_SBOX[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_add_round_key_sched.sv
// -----------------------------------------------------------------------------
// aes_add_round_key_sched
// AddRoundKey stage of the AES-128 encrypt datapath with on-the-fly key
// expansion. Each accepted beat is XORed with the current round key and
// registered; the round key then advances one schedule step. After the last
// round the master key is restored so back-to-back blocks need no reload.
// Ports:
//   i_clk        in   1    clock, all updates on posedge
//   i_rst        in   1    synchronous active-high reset
//   i_key_load   in   1    strobe: capture i_key_in as master key
//   i_key_in     in   128  cipher key, [127:96] = w0
//   o_key_valid  out  1    a master key has been loaded since reset
//   i_in_valid   in   1    i_in_state valid
//   o_in_ready   out  1    stage accepts a beat this cycle
//   i_in_state   in   128  state, column-major, [127:120] = row0/col0
//   o_out_valid  out  1    output valid
//   i_out_ready  in   1    downstream accepts output
//   o_out_state  out  128  i_in_state ^ round key
//   o_out_round  out  4    round index of the output (0..NUM_ROUNDS)
//   o_out_last   out  1    output is the final round (ciphertext)
// -----------------------------------------------------------------------------
module aes_add_round_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NR,
    parameter logic [7:0]  RCON_INIT  = AES_RCON_INIT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_key_load,
    input  logic [127:0] i_key_in,
    output logic         o_key_valid,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_state,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_state,
    output logic [3:0]   o_out_round,
    output logic         o_out_last
);

    localparam logic [3:0] LP_LAST_ROUND = 4'(NUM_ROUNDS);

    // Key schedule state
    aes_state_t r_mkey;
    aes_state_t r_rk;
    aes_byte_t  r_rcon;
    logic [3:0] r_round;
    logic       r_key_valid;

    // Output register
    logic       r_out_valid;
    aes_state_t r_out_state;
    logic [3:0] r_out_round;
    logic       r_out_last;

    // Handshake
    logic w_in_ready;
    logic w_accept;
    logic w_is_last;

    // Key step
    aes_word_t  w_rot;
    aes_word_t  w_sub;
    aes_word_t  w_t;
    aes_word_t  w_w0;
    aes_word_t  w_w1;
    aes_word_t  w_w2;
    aes_word_t  w_w3;
    aes_state_t w_rk_next;

    // key_load blocks acceptance so a beat can never pair with a stale key.
    assign w_in_ready = r_key_valid & ~i_key_load & (~r_out_valid | i_out_ready);
    assign w_accept   = i_in_valid & w_in_ready;
    assign w_is_last  = (r_round == LP_LAST_ROUND);

    // RotWord of w3: left-rotate by one byte.
    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t  = w_sub ^ {r_rcon, 24'h000000};
    assign w_w0 = r_rk[127:96] ^ w_t;
    assign w_w1 = r_rk[95:64]  ^ w_w0;
    assign w_w2 = r_rk[63:32]  ^ w_w1;
    assign w_w3 = r_rk[31:0]   ^ w_w2;
    assign w_rk_next = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mkey      <= '0;
            r_rk        <= '0;
            r_rcon      <= RCON_INIT;
            r_round     <= '0;
            r_key_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            r_out_round <= '0;
            r_out_last  <= 1'b0;
        end else if (i_key_load) begin
            // Abort any block in flight and restart from the new key.
            r_mkey      <= i_key_in;
            r_rk        <= i_key_in;
            r_rcon      <= RCON_INIT;
            r_round     <= '0;
            r_key_valid <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_state <= i_in_state ^ r_rk;
            r_out_round <= r_round;
            r_out_last  <= w_is_last;
            if (w_is_last) begin
                r_rk    <= r_mkey;
                r_rcon  <= RCON_INIT;
                r_round <= '0;
            end else begin
                r_rk    <= w_rk_next;
                r_rcon  <= xtime(r_rcon);
                r_round <= r_round + 4'd1;
            end
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_key_valid = r_key_valid;
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_state = r_out_state;
    assign o_out_round = r_out_round;
    assign o_out_last  = r_out_last;

endmodule
